// File: rtl/slave_rd_port.sv
// Read-side slave port: synchronises the burst request, reads a registered-output
// SRAM one beat at a time and returns byte-masked data with a one-cycle ready pulse.
//
// state  | meaning
// IDLE   | no burst; waiting for synchronised request
// ACCEPT | waiting for a valid beat; also the cycle in which ready/SRAM read is high
// FETCH  | SRAM data on iMemRdData; captured (masked) into oSlvRdData at its end
// GAP    | one dead cycle so a late-dropping valid cannot be accepted twice
// HOLD   | burst finished; hold data/err until request drops
module slave_rd_port #(
   parameter int AW        = 12,
   parameter int DW        = 32,
   parameter int SW        = DW / 8,
   parameter int MEM_DEPTH = 1024
) (
   input  logic                         iClk,
   input  logic                         iRst_n,
   input  logic                         iSlvRdReq,
   input  logic                         iSlvRdValid,
   input  logic [AW-1:0]                iSlvRdAddr,
   input  logic [SW-1:0]                iSlvRdSel,
   input  logic                         iSlvRdLast,
   output logic                         oSlvRdReady,
   output logic [DW-1:0]                oSlvRdData,
   output logic                         oSlvRdErr,
   output logic                         oMemRdEn,
   output logic [$clog2(MEM_DEPTH)-1:0] oMemAddr,
   input  logic [DW-1:0]                iMemRdData
);

   localparam int MAW = $clog2(MEM_DEPTH);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ACCEPT = 3'd1;
   localparam logic [2:0] ST_FETCH  = 3'd2;
   localparam logic [2:0] ST_GAP    = 3'd3;
   localparam logic [2:0] ST_HOLD   = 3'd4;

   logic [2:0]    state;
   logic          req_meta;
   logic          req_s;
   logic [SW-1:0] sel_q;
   logic          last_q;
   logic          legal_q;
   logic [15:0]   beat_cnt;
   logic          beat_legal;
   logic [DW-1:0] masked;

   always_comb begin
      beat_legal = (iSlvRdAddr[1:0] == 2'b00) &&
                   (32'(iSlvRdAddr[AW-1:2]) < $unsigned(MEM_DEPTH));
   end

   // Illegal beats never read the SRAM, so their data is forced to zero here.
   always_comb begin
      masked = '0;
      for (int i = 0; i < SW; i++) begin
         if (sel_q[i] && legal_q) begin
            masked[8*i +: 8] = iMemRdData[8*i +: 8];
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state       <= ST_IDLE;
         req_meta    <= 1'b0;
         req_s       <= 1'b0;
         sel_q       <= '0;
         last_q      <= 1'b0;
         legal_q     <= 1'b0;
         beat_cnt    <= '0;
         oSlvRdReady <= 1'b0;
         oSlvRdData  <= '0;
         oSlvRdErr   <= 1'b0;
         oMemRdEn    <= 1'b0;
         oMemAddr    <= '0;
      end else begin
         req_meta    <= iSlvRdReq;
         req_s       <= req_meta;
         oSlvRdReady <= 1'b0;
         oMemRdEn    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_s) begin
                  state     <= ST_ACCEPT;
                  oSlvRdErr <= 1'b0;
                  beat_cnt  <= '0;
               end
            end
            ST_ACCEPT: begin
               // Once ready is out the beat is committed and the read must complete.
               if (oSlvRdReady) begin
                  state <= ST_FETCH;
               end else if (!req_s) begin
                  state <= ST_IDLE;
               end else if (iSlvRdValid) begin
                  oSlvRdReady <= 1'b1;
                  oMemRdEn    <= beat_legal;
                  oMemAddr    <= MAW'(iSlvRdAddr[AW-1:2]);
                  sel_q       <= iSlvRdSel;
                  last_q      <= iSlvRdLast;
                  legal_q     <= beat_legal;
                  oSlvRdErr   <= oSlvRdErr | ~beat_legal;
                  beat_cnt    <= beat_cnt + 16'd1;
               end
            end
            ST_FETCH: begin
               oSlvRdData <= masked;
               state      <= last_q ? ST_HOLD : ST_GAP;
            end
            ST_GAP: begin
               state <= req_s ? ST_ACCEPT : ST_IDLE;
            end
            ST_HOLD: begin
               if (!req_s) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
